// File: rtl/decoder_pkg.sv
// Shared types, constants and helpers for the binary-to-one-hot decoder family.
package decoder_pkg;

  localparam int unsigned DEC_IN_W_DEFAULT = 2;
  localparam int unsigned DEC_IN_W_MAX     = 6;
  localparam int unsigned DEC_OUT_W_MAX    = 1 << DEC_IN_W_MAX;

  // Bits at or above 'width' are masked off so callers can safely truncate.
  function automatic logic [DEC_OUT_W_MAX-1:0] onehot(
    input logic [DEC_IN_W_MAX-1:0] code,
    input int unsigned             width
  );
    logic [DEC_OUT_W_MAX-1:0] mask;
    mask = (width >= DEC_OUT_W_MAX) ? '1
         : ((DEC_OUT_W_MAX'(1) << width) - DEC_OUT_W_MAX'(1));
    return (DEC_OUT_W_MAX'(1) << code) & mask;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational select-code to one-hot decode; all-zero when disabled.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W  = DEC_IN_W_DEFAULT,
  parameter int unsigned OUT_W = 1 << IN_W
) (
  input  logic [IN_W-1:0]  in_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] raw_o
);

  logic [DEC_OUT_W_MAX-1:0] fullOneHot;

  always_comb begin
    fullOneHot = onehot(DEC_IN_W_MAX'(in_i), OUT_W);
    raw_o      = en_i ? fullOneHot[OUT_W-1:0] : '0;
  end

endmodule

// File: rtl/decoder_2to4.sv
// Registered binary-to-one-hot decoder with enable and optional active-low outputs.
module decoder_2to4
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W       = DEC_IN_W_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b0,
  localparam int unsigned OUT_W     = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             out_valid
);

  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? '1 : '0;

  logic [OUT_W-1:0] rawOneHot;
  logic [OUT_W-1:0] out_d, out_q;
  logic             valid_d, valid_q;

  decoder_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_i  (in),
    .en_i  (en),
    .raw_o (rawOneHot)
  );

  // A disabled core yields all zeros, which inverts to the all-ones idle state.
  always_comb begin
    out_d   = ACTIVE_LOW ? ~rawOneHot : rawOneHot;
    valid_d = en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= INACTIVE;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_decoder_2to4.sv
// Self-checking bench: a default 2-to-4 instance and an active-low 3-to-8 instance.
module tb_decoder_2to4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enA, enB;
  logic [1:0] inA;
  logic [2:0] inB;
  logic [3:0] outA;
  logic [7:0] outB;
  logic       validA, validB;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_2to4 #(.IN_W(2)) dutA (
    .clk       (clk),
    .rst       (rst),
    .en        (enA),
    .in        (inA),
    .out       (outA),
    .out_valid (validA)
  );

  decoder_2to4 #(.IN_W(3), .ACTIVE_LOW(1'b1)) dutB (
    .clk       (clk),
    .rst       (rst),
    .en        (enB),
    .in        (inB),
    .out       (outB),
    .out_valid (validB)
  );

  // Reference: line number 'code' active means value 2**code; inactive lines otherwise.
  function automatic logic [3:0] modelA(input logic r, input logic e, input int code);
    if (r || !e) return 4'd0;
    return 4'(2 ** code);
  endfunction

  function automatic logic [7:0] modelB(input logic r, input logic e, input int code);
    if (r || !e) return 8'hFF;
    return 8'hFF - 8'(2 ** code);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enA = 1'b1; inA = 2'b10; enB = 1'b1; inB = 3'b101;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (outA !== 4'b0000 || validA !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_a cycle %0d: out=%b valid=%b, want out=0000 valid=0", c, outA, validA);
      end
      checks++;
      if (outB !== 8'hFF || validB !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_b cycle %0d: out=%h valid=%b, want out=ff valid=0", c, outB, validB);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (outA !== 4'b0100 || validA !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release: out=%b valid=%b, want out=0100 valid=1", outA, validA);
    end
  endtask

  task automatic test_enabled_sweep();
    logic [3:0] want [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    enA = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inA = 2'(i);
      tick();
      checks++;
      if (outA !== want[i] || validA !== 1'b1) begin
        failures++;
        $display("[TB] FAIL enabled_sweep in=%0d: out=%b valid=%b, want out=%b valid=1", i, outA, validA, want[i]);
      end
    end
  endtask

  task automatic test_disabled_sweep();
    enA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inA = 2'(i);
      tick();
      checks++;
      if (outA !== 4'b0000 || validA !== 1'b0) begin
        failures++;
        $display("[TB] FAIL disabled_sweep in=%0d: out=%b valid=%b, want out=0000 valid=0", i, outA, validA);
      end
    end
  endtask

  task automatic test_enable_toggle();
    logic       ens  [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] want [3] = '{4'b1000, 4'b0000, 4'b1000};
    inA = 2'b11;
    for (int i = 0; i < 3; i++) begin
      enA = ens[i];
      tick();
      checks++;
      if (outA !== want[i] || validA !== ens[i]) begin
        failures++;
        $display("[TB] FAIL enable_toggle step %0d: out=%b valid=%b, want out=%b valid=%b", i, outA, validA, want[i], ens[i]);
      end
    end
  endtask

  task automatic test_active_low();
    enB = 1'b1; inB = 3'b101;
    tick();
    checks++;
    if (outB !== 8'b11011111 || validB !== 1'b1) begin
      failures++;
      $display("[TB] FAIL active_low_decode: out=%b valid=%b, want out=11011111 valid=1", outB, validB);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (outB !== 8'hFF || validB !== 1'b0) begin
      failures++;
      $display("[TB] FAIL active_low_reset: out=%h valid=%b, want out=ff valid=0", outB, validB);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    enB = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inB = 3'(i);
      tick();
      checks++;
      if (~outB !== 8'(2 ** i) || validB !== 1'b1 || $countones(~outB) != 1) begin
        failures++;
        $display("[TB] FAIL back_to_back in=%0d: active-high view=%b valid=%b, want %b valid=1", i, ~outB, validB, 8'(2 ** i));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] wantA;
    logic [7:0] wantB;
    for (int i = 0; i < 60; i++) begin
      rst = ($urandom_range(0, 7) == 0);
      enA = 1'($urandom);
      enB = 1'($urandom);
      inA = 2'($urandom);
      inB = 3'($urandom);
      wantA = modelA(rst, enA, int'(inA));
      wantB = modelB(rst, enB, int'(inB));
      tick();
      checks++;
      if (outA !== wantA || validA !== (!rst && enA)) begin
        failures++;
        $display("[TB] FAIL random_a iter %0d: out=%b valid=%b, want out=%b valid=%b", i, outA, validA, wantA, !rst && enA);
      end
      checks++;
      if (outB !== wantB || validB !== (!rst && enB)) begin
        failures++;
        $display("[TB] FAIL random_b iter %0d: out=%b valid=%b, want out=%b valid=%b", i, outB, validB, wantB, !rst && enB);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enA = 1'b0; enB = 1'b0; inA = '0; inB = '0;
    test_reset();
    test_enabled_sweep();
    test_disabled_sweep();
    test_enable_toggle();
    test_active_low();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
